// File: rtl/des_keysched_seq.sv
// DES key schedule: PC-1 on load, then one PC-2 subkey per valid/ready handshake from a rotating C/D register.
// Latency: first subkey valid the cycle after key_load; one subkey per cycle with ready held high.
// Backpressure: subkey_ready low holds state, C/D and subkey; key_load always wins and restarts.
module des_keysched_seq #(
    parameter bit DECRYPT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        key_load,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        last
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    localparam logic [3:0] FIRST_IDX = DECRYPT ? 4'd15 : 4'd0;
    localparam logic [3:0] LAST_IDX  = DECRYPT ? 4'd0  : 4'd15;

    // Tables hold standard (1-based, MSB-first) bit numbers.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return r;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [27:0] c_half_q, c_half_d;
    logic [27:0] d_half_q, d_half_d;
    logic [3:0]  round_idx_q, round_idx_d;

    logic [55:0] key_pc1;
    logic [27:0] c_rot, d_rot;
    logic        one_shift;
    logic        handshake;

    assign subkey_valid = (state_q == ST_EMIT);
    assign busy         = (state_q == ST_EMIT);
    assign last         = (state_q == ST_EMIT) && (round_idx_q == LAST_IDX);
    assign round_idx    = round_idx_q;
    assign subkey       = pc2({c_half_q, d_half_q});
    assign handshake    = subkey_valid & subkey_ready;

    // Step to the neighbouring round: right by s(idx+1) going down, left by s(idx+2) going up.
    always_comb begin
        one_shift = 1'b0;
        c_rot     = c_half_q;
        d_rot     = d_half_q;
        if (DECRYPT) begin
            one_shift = (round_idx_q == 4'd0) || (round_idx_q == 4'd1) ||
                        (round_idx_q == 4'd8) || (round_idx_q == 4'd15);
            c_rot = one_shift ? {c_half_q[0], c_half_q[27:1]} : {c_half_q[1:0], c_half_q[27:2]};
            d_rot = one_shift ? {d_half_q[0], d_half_q[27:1]} : {d_half_q[1:0], d_half_q[27:2]};
        end else begin
            one_shift = (round_idx_q == 4'd0) || (round_idx_q == 4'd7) ||
                        (round_idx_q == 4'd14);
            c_rot = one_shift ? {c_half_q[26:0], c_half_q[27]} : {c_half_q[25:0], c_half_q[27:26]};
            d_rot = one_shift ? {d_half_q[26:0], d_half_q[27]} : {d_half_q[25:0], d_half_q[27:26]};
        end
    end

    // Decrypt starts from C0D0 unrotated since the 16 shifts sum to 28 and C16D16 = C0D0.
    always_comb begin
        key_pc1     = pc1(key_in);
        state_d     = state_q;
        c_half_d    = c_half_q;
        d_half_d    = d_half_q;
        round_idx_d = round_idx_q;
        if (key_load) begin
            state_d     = ST_EMIT;
            round_idx_d = FIRST_IDX;
            if (DECRYPT) begin
                c_half_d = key_pc1[55:28];
                d_half_d = key_pc1[27:0];
            end else begin
                c_half_d = {key_pc1[54:28], key_pc1[55]};
                d_half_d = {key_pc1[26:0], key_pc1[27]};
            end
        end else if (handshake) begin
            if (last) begin
                state_d = ST_IDLE;
            end else begin
                c_half_d    = c_rot;
                d_half_d    = d_rot;
                round_idx_d = DECRYPT ? (round_idx_q - 4'd1) : (round_idx_q + 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            c_half_q    <= '0;
            d_half_q    <= '0;
            round_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            c_half_q    <= c_half_d;
            d_half_q    <= d_half_d;
            round_idx_q <= round_idx_d;
        end
    end

endmodule
